sd_fifo_head_pkt: RTL



---
 rtl/sd_fifo_pkg.sv | 28 ++
 rtl/sd_fifo_head_pkt_if.sv | 21 ++
 rtl/sd_fifo_head_pkt.sv | 95 +++++++++
 3 files changed

// File: rtl/sd_fifo_pkg.sv
// Shared helpers for the S FIFO head/tail pair: pointer grey coding and clocking defines.
`ifndef SDLIB_CLOCKING
`define SDLIB_CLOCKING posedge clk or negedge reset
`endif
`ifndef SDLIB_DELAY
`define SDLIB_DELAY
`endif

package sd_fifo_pkg;

    // Wide enough for any pointer; callers zero-extend in and slice their width back out.
    localparam int unsigned PtrMaxW = 32;
    typedef logic [PtrMaxW-1:0] ptr_t;

    function automatic ptr_t bin2grey(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t grey2bin(input ptr_t grey);
        ptr_t bin;
        bin[PtrMaxW-1] = grey[PtrMaxW-1];
        for (int i = PtrMaxW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ grey[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sd_fifo_head_pkt_if.sv
// Producer-side packet handshake between a source and sd_fifo_head_pkt.
interface sd_fifo_head_pkt_if #(
    parameter int unsigned asz = 4
);
    logic           c_srdy;
    logic           c_drdy;
    logic           c_commit;
    logic           c_abort;
    logic [asz:0]   c_usage;
    logic           c_drop;

    modport master (
        output c_srdy, c_commit, c_abort,
        input  c_drdy, c_usage, c_drop
    );

    modport slave (
        input  c_srdy, c_commit, c_abort,
        output c_drdy, c_usage, c_drop
    );
endinterface

// File: rtl/sd_fifo_head_pkt.sv
// Write-side controller for the S FIFO with commit/abort packet semantics.
// Define SD_FIFO_HEAD_DROP_EN to drop overflowing packets instead of back-pressuring.
module sd_fifo_head_pkt
    import sd_fifo_pkg::*;
#(
    parameter int unsigned depth = 16,
    parameter int unsigned async = 0,
    parameter int unsigned asz   = $clog2(depth)
) (
    input  logic            clk,
    input  logic            reset,
    sd_fifo_head_pkt_if.slave c,
    output logic            wr_en,
    output logic [asz-1:0]  wr_addr,
    output logic [asz:0]    wrptr_head,
    input  logic [asz:0]    rdptr_tail
);

    logic [asz:0] wrptr, cptr, nxt_wrptr, nxt_cptr;
    logic [asz:0] rdptr, head_grey;
    logic         full;
    ptr_t         rd_bin_ext, head_grey_ext;
    logic         unused_ext;

    always_comb begin
        rd_bin_ext    = grey2bin(ptr_t'(rdptr_tail));
        head_grey_ext = bin2grey(ptr_t'(nxt_cptr));
    end

    assign unused_ext = ^{rd_bin_ext[PtrMaxW-1:asz+1], head_grey_ext[PtrMaxW-1:asz+1]};
    assign rdptr      = (async != 0) ? rd_bin_ext[asz:0] : rdptr_tail;
    assign full       = (wrptr[asz] != rdptr[asz]) && (wrptr[asz-1:0] == rdptr[asz-1:0]);
    assign c.c_usage  = wrptr - rdptr;
    assign wr_addr    = wrptr[asz-1:0];
    assign wrptr_head = (async != 0) ? head_grey : cptr;

`ifdef SD_FIFO_HEAD_DROP_EN
    logic drop, drop_pulse, drop_hit, drop_end;

    // A refused word while full condemns the rest of the packet, unless it is being aborted.
    assign drop_hit = drop | (c.c_srdy & full & ~c.c_abort);
    assign drop_end = drop_hit & (c.c_commit | c.c_abort);
    assign c.c_drdy = ~full | drop;
    assign wr_en    = c.c_srdy & c.c_drdy & ~c.c_abort & ~drop;
    assign c.c_drop = drop_pulse;
`else
    assign c.c_drdy = ~full;
    assign wr_en    = c.c_srdy & c.c_drdy & ~c.c_abort;
    assign c.c_drop = 1'b0;
`endif

    always_comb begin
        nxt_wrptr = wrptr;
        nxt_cptr  = cptr;
        if (c.c_abort) begin
            nxt_wrptr = cptr;
        end else if (wr_en) begin
            nxt_wrptr = wrptr + 1'b1;
        end
        if (!c.c_abort && c.c_commit) begin
            nxt_cptr = nxt_wrptr;
        end
`ifdef SD_FIFO_HEAD_DROP_EN
        if (drop_end) begin
            nxt_wrptr = cptr;
            nxt_cptr  = cptr;
        end
`endif
    end

    always_ff @(`SDLIB_CLOCKING) begin
        if (!reset) begin
            wrptr     <= '0;
            cptr      <= '0;
            head_grey <= '0;
        end else begin
            wrptr     <= nxt_wrptr;
            cptr      <= nxt_cptr;
            head_grey <= head_grey_ext[asz:0];
        end
    end

`ifdef SD_FIFO_HEAD_DROP_EN
    always_ff @(`SDLIB_CLOCKING) begin
        if (!reset) begin
            drop       <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            drop       <= drop_hit & ~drop_end;
            drop_pulse <= drop_end;
        end
    end
`endif

endmodule
